// File: rtl/race_runner.sv
// race_runner: single-run sequencer. An accepted start launches a run of
// 'duration' cycles (0 behaves as 1). The run ends with a one-cycle done
// pulse and a run counter increment, followed by a cooldown of COOL cycles.
// An abort during the run cancels it silently. A start seen while not ready
// sets a sticky protocol error, except during DONE/COOL, where an early
// request is legal and is ignored without setting the flag.
module race_runner #(
  parameter int CNT_W = 8,
  parameter int COOL  = 2
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             start,
  input  logic [CNT_W-1:0] duration,
  input  logic             abort,
  output logic             ready,
  output logic             done,
  output logic [CNT_W-1:0] run_count,
  output logic             proto_err
);

  localparam int CW    = (COOL > 1) ? $clog2(COOL) : 1;
  localparam int CLOAD = (COOL > 0) ? COOL - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_COOL} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]    cool_q, cool_d;
  logic [CNT_W-1:0] rc_q, rc_d;
  logic             perr_q, perr_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             accept;

  // A start is only taken when the registered ready was high before the edge.
  assign accept = start & ready_q;

  // Next-state, counters and flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cool_d  = cool_q;
    rc_d    = rc_q;
    perr_d  = perr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RUN;
          cnt_d   = (duration == '0) ? CNT_W'(1) : duration;
        end
      end
      S_RUN: begin
        // Abort takes priority over normal expiry on the same edge.
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
          rc_d    = rc_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (COOL == 0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_COOL;
          cool_d  = CW'(CLOAD);
        end
      end
      S_COOL: begin
        if (cool_q == '0) state_d = S_IDLE;
        else              cool_d  = cool_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    // Early requests during DONE/COOL are tolerated; anywhere else they are errors.
    if (start && !ready_q && state_q != S_DONE && state_q != S_COOL)
      perr_d = 1'b1;
  end

  // Outputs are registered off the next state so they line up with it.
  assign ready_d = (state_d == S_IDLE);
  assign done_d  = (state_d == S_DONE);

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cool_q  <= '0;
      rc_q    <= '0;
      perr_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cool_q  <= cool_d;
      rc_q    <= rc_d;
      perr_q  <= perr_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign run_count = rc_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_race_runner.sv
// Bench for race_runner: timeline-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_race_runner;
  localparam int CNT_W = 8;
  localparam int COOL  = 2;

  logic             clk;
  logic             rst_l;
  logic             start;
  logic [CNT_W-1:0] duration;
  logic             abort;
  logic             ready;
  logic             done;
  logic [CNT_W-1:0] run_count;
  logic             proto_err;

  int checks   = 0;
  int failures = 0;

  race_runner #(.CNT_W(CNT_W), .COOL(COOL)) dut (
    .clk(clk), .rst_l(rst_l), .start(start), .duration(duration),
    .abort(abort), .ready(ready), .done(done), .run_count(run_count),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is described by the edge its done lands on and
  // the edge from which the block is idle again.
  int               e;
  int               done_e;
  int               idle_e;
  int               d;
  logic             m_ready, m_done, m_perr, pr, in_run, in_dc;
  logic [CNT_W-1:0] m_cnt;

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      m_ready = 1'b0; m_done = 1'b0; m_perr = 1'b0; m_cnt = '0;
      done_e  = -10;  idle_e = -10;
    end else begin
      e++;
      pr     = m_ready;
      in_run = (e <= done_e);
      in_dc  = (e > done_e) && (e <= idle_e);
      if (start && !pr && !in_dc) m_perr = 1'b1;
      if (in_run && abort) begin
        done_e = -10;
        idle_e = e;
      end else if (start && pr) begin
        d      = (duration == 0) ? 1 : int'(duration);
        done_e = e + d;
        idle_e = done_e + 1 + COOL;
      end
      m_done = (e == done_e);
      if (m_done) m_cnt = m_cnt + 1'b1;
      m_ready = (e >= idle_e);
    end
  end

  // Every cycle: outputs against the model, plus ready/done exclusion.
  always @(negedge clk) begin
    chk("m_ready", ready, m_ready);
    chk("m_done", done, m_done);
    chk("m_count", run_count, m_cnt);
    chk("m_perr", proto_err, m_perr);
    chk("excl", ready & done, 1'b0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int last_done, dones, budget;

  initial begin
    e = 0;
    rst_l = 1'b0; start = 1'b0; duration = '0; abort = 1'b0;
    #3;
    chk("rst_ready", ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_count", run_count, 8'd0);
    chk("rst_perr", proto_err, 1'b0);
    #19 rst_l = 1'b1;               // released between edges
    step();
    chk("ready_after_rel", ready, 1'b1);

    // Basic run, duration 5: done only at k+5, idle again at k+8.
    start = 1'b1; duration = 8'd5;
    step();                          // edge k
    chk("basic_ready_k", ready, 1'b0);
    start = 1'b0;
    repeat (4) step();               // k+4
    chk("basic_no_done", done, 1'b0);
    step();                          // k+5
    chk("basic_done", done, 1'b1);
    chk("basic_count", run_count, 8'd1);
    step();                          // k+6
    chk("basic_done_off", done, 1'b0);
    step();                          // k+7
    chk("basic_cool", ready, 1'b0);
    step();                          // k+8
    chk("basic_ready", ready, 1'b1);

    // Zero duration behaves as 1.
    start = 1'b1; duration = 8'd0;
    step();
    start = 1'b0;
    step();
    chk("zero_done", done, 1'b1);
    chk("zero_count", run_count, 8'd2);
    repeat (3) step();
    chk("zero_ready", ready, 1'b1);

    // Abort on the expiry edge wins.
    start = 1'b1; duration = 8'd3;
    step();
    start = 1'b0;
    repeat (2) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("coll_done", done, 1'b0);
    chk("coll_ready", ready, 1'b1);
    chk("coll_count", run_count, 8'd2);
    chk("coll_perr", proto_err, 1'b0);

    // Start during COOL is silent.
    start = 1'b1; duration = 8'd2;
    step();                          // k
    start = 1'b0;
    repeat (3) step();               // k+3: in COOL
    start = 1'b1;
    step();                          // k+4: sampled in COOL
    start = 1'b0;
    chk("cool_perr", proto_err, 1'b0);
    chk("cool_count", run_count, 8'd3);
    step();
    chk("cool_ready", ready, 1'b1);

    // Start mid-RUN flags an error but the run keeps its timing.
    start = 1'b1; duration = 8'd4;
    step();                          // k
    start = 1'b0;
    step();
    start = 1'b1;
    step();                          // k+2
    start = 1'b0;
    chk("mid_perr", proto_err, 1'b1);
    step(); step();                  // k+4
    chk("mid_done", done, 1'b1);
    chk("mid_count", run_count, 8'd4);
    repeat (3) step();

    // Wrap with start held high and duration 1.
    rst_l = 1'b0;
    #3 rst_l = 1'b1;
    step();
    chk("wrap_perr_clr", proto_err, 1'b0);
    start = 1'b1; duration = 8'd1;
    dones = 0; last_done = 0; budget = 0;
    while (dones < 256 && budget < 1400) begin
      step();
      budget++;
      if (done) begin
        if (dones > 0) chk("wrap_spacing", budget - last_done, 5);
        last_done = budget;
        dones++;
      end
    end
    start = 1'b0;
    chk("wrap_dones", dones, 256);
    chk("wrap_count", run_count, 8'd0);
    repeat (4) step();

    // Async reset mid-RUN: outputs clear before the next edge, no late done.
    start = 1'b1; duration = 8'd10;
    step();
    start = 1'b0;
    repeat (2) step();
    #2 rst_l = 1'b0;
    #1;
    chk("ar_ready", ready, 1'b0);
    chk("ar_done", done, 1'b0);
    chk("ar_count", run_count, 8'd0);
    chk("ar_perr", proto_err, 1'b0);
    step();
    #2 rst_l = 1'b1;
    step();
    chk("ar_ready_rel", ready, 1'b1);
    repeat (12) begin
      step();
      chk("ar_no_done", done, 1'b0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 99) < 30);
      duration = CNT_W'($urandom_range(0, 9));
      abort    = ($urandom_range(0, 99) < 10);
      rst_l    = ($urandom_range(0, 999) >= 4);
      step();
    end
    rst_l = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
